// File: rtl/trace_frame_builder.sv
// TPIU sync detector and frame builder for trace half-words. Finds 0xFFFF/0x7FFF full sync,
// strips padding and emits payload in 8-word frames, rolling back partial frames on loss or realign.
module trace_frame_builder #(
  parameter int SYNC_LOSS_LOG2 = 12
) (
  input  logic        wrClk,
  input  logic        rst,
  input  logic [15:0] TraceWd,
  input  logic        TraceWdAvail,
  output logic        WdAvail,
  output logic [15:0] PacketWd,
  output logic        PacketReset,
  output logic        sync,
  output logic [15:0] FrameCount
);

  localparam int DATA_W = 16;
  localparam logic [DATA_W-1:0] FULL_SYNC_HI = 16'hFFFF;
  localparam logic [DATA_W-1:0] HALF_SYNC    = 16'h7FFF;
  localparam logic [SYNC_LOSS_LOG2-1:0] LOSS_TOP = '1;

  typedef enum logic {
    UNSYNC = 1'b0,
    SYNCED = 1'b1
  } state_t;

  state_t                    state;
  logic [DATA_W-1:0]         hold_wd_p0;
  logic                      hold_vld_p0;
  logic [2:0]                word_idx;
  logic [SYNC_LOSS_LOG2-1:0] loss_cnt;

  logic                      full_sync;
  logic                      half_sync;
  logic [SYNC_LOSS_LOG2-1:0] loss_next;
  logic                      loss_hit;

  function automatic logic [SYNC_LOSS_LOG2-1:0] sat_inc(input logic [SYNC_LOSS_LOG2-1:0] v);
    if (v == LOSS_TOP) return v;
    return v + {{(SYNC_LOSS_LOG2-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    full_sync = hold_vld_p0 && (hold_wd_p0 == FULL_SYNC_HI) && (TraceWd == HALF_SYNC);
    half_sync = (hold_wd_p0 == HALF_SYNC);
    loss_next = sat_inc(loss_cnt);
    loss_hit  = (state == SYNCED) && (loss_next == LOSS_TOP);
  end

  // Stage p0 -> outputs: held word is judged against the incoming word on each strobe
  always_ff @(posedge wrClk) begin
    if (rst) begin
      state       <= UNSYNC;
      hold_wd_p0  <= '0;
      hold_vld_p0 <= 1'b0;
      word_idx    <= '0;
      loss_cnt    <= '0;
      WdAvail     <= 1'b0;
      PacketWd    <= '0;
      PacketReset <= 1'b0;
      sync        <= 1'b0;
      FrameCount  <= '0;
    end else begin
      WdAvail     <= 1'b0;
      PacketReset <= 1'b0;
      if (TraceWdAvail) begin
        hold_wd_p0  <= TraceWd;
        hold_vld_p0 <= 1'b1;
        if (full_sync) begin
          hold_vld_p0 <= 1'b0;
          loss_cnt    <= '0;
          state       <= SYNCED;
          sync        <= 1'b1;
          if (word_idx != 3'd0) begin
            PacketReset <= 1'b1;
            word_idx    <= '0;
          end
        end else if (loss_hit) begin
          // Held word is dropped; any partial frame is rolled back downstream
          loss_cnt <= loss_next;
          state    <= UNSYNC;
          sync     <= 1'b0;
          if (word_idx != 3'd0) begin
            PacketReset <= 1'b1;
            word_idx    <= '0;
          end
        end else begin
          if (state == SYNCED) loss_cnt <= loss_next;
          if (hold_vld_p0 && !half_sync && (state == SYNCED)) begin
            WdAvail  <= 1'b1;
            PacketWd <= hold_wd_p0;
            word_idx <= word_idx + 3'd1;
            if (word_idx == 3'd7) FrameCount <= FrameCount + 16'd1;
          end
        end
      end
    end
  end

endmodule
